// File: rtl/csa64_seq_pkg.sv
// csa64_seq_pkg: shared state encoding and defaults for the csa64 op sequencer
package csa64_seq_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int TIMEOUT_DEF = 255;
  localparam int CTR_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/csa64_timeout_ctr.sv
// csa64_timeout_ctr: clearable wait-cycle counter with terminal-count flag
module csa64_timeout_ctr import csa64_seq_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  logic [CTR_W-1:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + CTR_W'(1);
  assign tc = count == CTR_W'(TIMEOUT);
endmodule

// File: rtl/csa64_op_sequencer.sv
// csa64_op_sequencer: request/response front end driving the adder start/complete handshake
module csa64_op_sequencer import csa64_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  input  logic             req_cin,
  output logic [WIDTH-1:0] ope1,
  output logic [WIDTH-1:0] ope2,
  output logic             Cin,
  output logic             add_sub,
  output logic             start,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             complete,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err
);
  state_t state, nxt;
  logic acc, clr, en, tc, cap, tmo, b_msb, ovf;
  csa64_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clock(clock), .reset(reset), .clear(clr), .enable(en), .tc(tc)
  );
  assign acc = req_valid & req_ready;
  assign b_msb = add_sub ^ ope2[WIDTH-1];
  assign ovf = (ope1[WIDTH-1] == b_msb) & (sum[WIDTH-1] != ope1[WIDTH-1]);
  always_comb begin
    nxt = state;
    clr = 1'b0;
    en = 1'b0;
    cap = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: nxt = acc ? ISSUE : IDLE;
      ISSUE: begin
        clr = 1'b1;
        nxt = WAIT;
      end
      WAIT: begin
        en = 1'b1;
        cap = complete;
        tmo = ~complete & tc;
        nxt = (complete | tc) ? RESP : WAIT;
      end
      RESP: nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  // every output is a flop loaded from the next state, so nothing combinational leaks out
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b0;
      start <= 1'b0;
      rsp_valid <= 1'b0;
      ope1 <= '0;
      ope2 <= '0;
      Cin <= 1'b0;
      add_sub <= 1'b0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      req_ready <= nxt == IDLE;
      start <= (nxt == ISSUE) | (nxt == WAIT);
      rsp_valid <= nxt == RESP;
      if (acc) begin
        ope1 <= req_a;
        ope2 <= req_b;
        Cin <= req_cin;
        add_sub <= req_sub;
      end
      if (cap) begin
        rsp_sum <= sum;
        rsp_cout <= cout;
        rsp_ovf <= ovf;
        rsp_err <= 1'b0;
      end else if (tmo) begin
        rsp_sum <= '0;
        rsp_cout <= 1'b0;
        rsp_ovf <= 1'b0;
        rsp_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_csa64_op_sequencer.sv
// tb_csa64_op_sequencer: directed vector table plus reset and backpressure sequences
module tb_csa64_op_sequencer;
  localparam int TMO = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_sub = 1'b0, req_cin = 1'b0;
  logic [63:0] req_a = '0, req_b = '0, ope1, ope2, sum = '0, rsp_sum;
  logic Cin, add_sub, start, cout = 1'b0, complete = 1'b0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_ovf, rsp_err;
  int checks = 0, errors = 0;
  typedef struct {
    logic [63:0] a, b;
    logic sub, cin, stale;
    int lat, hold;
    logic [63:0] esum;
    logic ecout, eovf, eerr;
  } vec_t;
  vec_t v[8];
  csa64_op_sequencer #(.WIDTH(64), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_cin(req_cin),
    .ope1(ope1), .ope2(ope2), .Cin(Cin), .add_sub(add_sub), .start(start),
    .sum(sum), .cout(cout), .complete(complete), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t t);
    int k, got;
    logic [64:0] r;
    k = 0;
    while (!req_ready && k < 10) begin
      @(posedge clock); #1;
      k++;
    end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_a = t.a; req_b = t.b; req_sub = t.sub; req_cin = t.cin; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("start_issue", 64'(start), 64'd1);
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    chk("ope1", ope1, t.a);
    chk("ope2", ope2, t.b);
    chk("add_sub_cin", {62'd0, add_sub, Cin}, {62'd0, t.sub, t.cin});
    complete = t.stale; sum = t.stale ? '1 : '0; cout = t.stale;
    got = 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(posedge clock); #1;
      if (rsp_valid) got = c;
      else begin
        chk("start_wait", 64'(start), 64'd1);
        r = {1'b0, ope1} + {1'b0, add_sub ? ~ope2 : ope2} + 65'(Cin);
        complete = c == t.lat; sum = r[63:0]; cout = r[64];
      end
    end
    complete = 1'b0;
    chk("rsp_cycle", 64'(got), 64'(t.lat > 0 ? t.lat + 1 : TMO + 2));
    chk("start_resp", 64'(start), 64'd0);
    chk("rsp_sum", rsp_sum, t.esum);
    chk("rsp_flags", {61'd0, rsp_cout, rsp_ovf, rsp_err}, {61'd0, t.ecout, t.eovf, t.eerr});
    if (t.hold > 0) begin
      req_valid = 1'b1; req_a = 64'hDEAD; req_b = 64'hBEEF;
      for (int h = 0; h < t.hold; h++) begin
        @(posedge clock); #1;
        chk("bp_sum", rsp_sum, t.esum);
        chk("bp_state", {60'd0, rsp_valid, req_ready, start, rsp_cout}, {60'd0, 1'b1, 1'b0, 1'b0, t.ecout});
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("handshake", {61'd0, rsp_valid, req_ready, start}, {61'd0, 1'b0, 1'b1, 1'b0});
  endtask
  initial begin
    v[0] = '{64'd5, 64'd7, 1'b0, 1'b0, 1'b0, 2, 0, 64'd12, 1'b0, 1'b0, 1'b0};
    v[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 1, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    v[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1'b0, 3, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    v[3] = '{64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0, 1'b0, 1'b0, 1'b1};
    v[4] = '{64'd10, 64'd20, 1'b0, 1'b0, 1'b0, 5, 0, 64'd30, 1'b0, 1'b0, 1'b0};
    v[5] = '{64'd1, 64'd2, 1'b0, 1'b0, 1'b1, 3, 0, 64'd3, 1'b0, 1'b0, 1'b0};
    v[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 2, 10, 64'd0, 1'b1, 1'b0, 1'b0};
    v[7] = '{64'd5, 64'd7, 1'b1, 1'b1, 1'b0, 2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", {ope1 | ope2 | rsp_sum}, 64'd0);
    chk("reset_flags", {55'd0, req_ready, start, rsp_valid, Cin, add_sub, rsp_cout, rsp_ovf, rsp_err, 1'b0}, 64'd0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    for (int i = 0; i < 8; i++) run(v[i]);
    req_a = 64'd9; req_b = 64'd9; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    chk("pre_reset_start", 64'(start), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset_wait_start", 64'(start), 64'd0);
    chk("reset_wait_flags", {61'd0, rsp_valid, req_ready, 1'b0}, 64'd0);
    chk("reset_wait_ope", ope1, 64'd0);
    @(posedge clock); #3 reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("post_reset_idle", {62'd0, rsp_valid, start}, 64'd0);
    end
    run(v[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa64_op_sequencer.md
# csa64_op_sequencer

Initiator-side controller for the 64-bit conditional sum adder. Accepts add/subtract requests on a valid/ready port, registers operands, drives the adder's `start`/`add_sub` interface, waits for `complete`, and returns the captured sum, carry, signed overflow and timeout status on a valid/ready response port. It sits between any datapath client and the adder so that clients never handle the adder's start/complete protocol directly.

## Interface
- `WIDTH`, 64: operand and sum width.
- `TIMEOUT`, 255: maximum WAIT cycles before the operation is abandoned (1..255).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_a`, `req_b`  in  WIDTH  operands.
- `req_sub`  in  1  1 = subtract, 0 = add.
- `req_cin`  in  1  carry-in.
- `ope1`, `ope2`  out  WIDTH  registered operands to adder.
- `Cin`, `add_sub`  out  1  registered carry-in / mode to adder.
- `start`  out  1  adder start, held high for the whole operation.
- `sum`  in  WIDTH  adder result.
- `cout`, `complete`  in  1  adder carry-out / done.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  client accepts response.
- `rsp_sum`  out  WIDTH  captured sum.
- `rsp_cout`, `rsp_ovf`, `rsp_err`  out  1  carry, signed overflow, timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`, register `req_a`→`ope1`, `req_b`→`ope2`, `req_cin`→`Cin`, `req_sub`→`add_sub`; go to ISSUE.
- ISSUE (exactly 1 cycle): `start`=1; `complete` ignored (stale); clear timeout counter; go to WAIT.
- WAIT: `start`=1; counter increments each cycle. If `complete`=1: capture `sum`, `cout`, compute `rsp_ovf`, `rsp_err`=0, go to RESP. Else if counter == TIMEOUT: `rsp_sum`=0, `rsp_cout`=0, `rsp_ovf`=0, `rsp_err`=1, go to RESP. `complete` wins if both occur in the same cycle.
- RESP: `start`=0, `rsp_valid`=1, outputs stable until `rsp_valid`&`rsp_ready`; then IDLE. No new request accepted in the handshake cycle (`req_ready` is 0 outside IDLE).
- Overflow: b_eff = `add_sub` ? ~`ope2` : `ope2`; `rsp_ovf` = (`ope1`[MSB] == b_eff[MSB]) & (`sum`[MSB] != `ope1`[MSB]). Computed only from registered operands and captured sum.
- Operands and mode are passed unmodified; subtraction semantics (inversion, carry) are the adder's.
- Reset (any state): all outputs 0, state IDLE, counter 0, in-flight result discarded, `start` drops asynchronously.

## Timing
- Reset values: `req_ready`=0 while `reset` asserted, 1 in the first cycle after release; `start`, `rsp_valid`, `rsp_sum`, `rsp_cout`, `rsp_ovf`, `rsp_err`, `ope1`, `ope2`, `Cin`, `add_sub` all 0.
- Request accepted at edge N → `start` high from N+1; earliest `complete` sample at N+2; `rsp_valid` high at N+3 at the earliest.
- Timeout: `rsp_valid` rises TIMEOUT+2 cycles after ISSUE.
- All outputs registered; no combinational path from `req_*` or `sum` to any output.
- Throughput: one operation per (latency + 1 return-to-IDLE cycle) minimum.

## Structure
- Shared package `csa64_seq_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), `WIDTH` default, `TIMEOUT` default, counter width (8).
- One sub-module: `csa64_timeout_ctr` (clear, enable, terminal-count compare); everything else in the top module.

## Test plan
- Add: a=5, b=7, cin=0, adder model returns sum=12, `complete` 2 cycles after start → `rsp_sum`=12, `rsp_cout`=0, `rsp_ovf`=0, `rsp_err`=0, `start` falls in RESP.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → `rsp_sum`=0x8000_0000_0000_0000, `rsp_ovf`=1; sub a=0x8000…0, b=1 → sum 0x7FFF…F, `rsp_ovf`=1.
- Timeout: TIMEOUT=4, `complete` held 0 → `rsp_err`=1, `rsp_sum`=0, `rsp_valid` 6 cycles after ISSUE; `complete` arriving on the terminal cycle → `rsp_err`=0.
- Backpressure: `rsp_ready`=0 for 10 cycles → `rsp_*` stable, `req_ready`=0, second `req_valid` not accepted until the cycle after handshake.
- Stale complete: `complete`=1 during ISSUE then 0 → not captured; capture only on a later WAIT `complete`.
- Reset in WAIT: assert `reset` → `start`=0 immediately, no `rsp_valid`, next request processes normally.
